seg7_scan_scheduler: RTL and testbench



---
 rtl/seg7_scan_scheduler.sv | 149 ++++++++++++++
 tb/tb_seg7_scan_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_scheduler.sv
// Multiplexed 4-digit common-anode 7-segment scan driver with a double-buffered frame store,
// blanking gaps between digits, and a frame-synchronous step tick for pattern generators.
module seg7_scan_scheduler #(
    parameter int DWELL       = 50000,
    parameter int BLANK       = 500,
    parameter int STEP_FRAMES = 48
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_valid_i,
    output logic       wr_ready_o,
    input  logic [1:0] wr_digit_i,
    input  logic [7:0] wr_seg_i,
    input  logic       commit_valid_i,
    output logic       commit_ready_o,
    output logic [3:0] an_o,
    output logic [7:0] seg_o,
    output logic       frame_done_o,
    output logic       step_tick_o
);

    localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int FRM_W   = $clog2(STEP_FRAMES + 1);

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK - 1);
    localparam logic [FRM_W-1:0] STEP_LAST  = FRM_W'(STEP_FRAMES - 1);

    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [FRM_W-1:0]  frm_q, frm_d;
    logic              pending_q, pending_d;
    logic [3:0][7:0]   front_q;
    logic [3:0][7:0]   back_q;
    logic [3:0]        an_q, an_d;
    logic [7:0]        seg_q, seg_d;

    logic frame_done;
    logic step_tick;
    logic wr_acc;
    logic commit_acc;
    logic swap;

    assign frame_done = (state_q == S_DRIVE) && (idx_q == 2'd3) && (cnt_q == DWELL_LAST);
    assign step_tick  = frame_done && (frm_q == STEP_LAST);
    assign wr_acc     = wr_valid_i & ~pending_q;
    assign commit_acc = commit_valid_i & ~pending_q;
    // A commit landing on the frame boundary itself swaps immediately, never going pending.
    assign swap       = frame_done & (pending_q | commit_acc);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        case (state_q)
            S_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                end
            end
            S_DRIVE: begin
                if (cnt_q == DWELL_LAST) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: begin
                state_d = S_BLANK;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        frm_d = frm_q;
        if (frame_done) begin
            frm_d = step_tick ? '0 : frm_q + FRM_W'(1);
        end

        pending_d = pending_q;
        if (swap) begin
            pending_d = 1'b0;
        end else if (commit_acc) begin
            pending_d = 1'b1;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = 8'hFF;
        if (state_d == S_DRIVE) begin
            an_d  = ~(4'b0001 << idx_d);
            seg_d = front_q[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_BLANK;
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            frm_q     <= '0;
            pending_q <= 1'b0;
            an_q      <= 4'b1111;
            seg_q     <= 8'hFF;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            frm_q     <= frm_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    // The swap copies the pre-edge back bank, so a same-cycle write lands in back only.
    always_ff @(posedge clk) begin
        if (reset) begin
            front_q <= {4{8'hFF}};
            back_q  <= {4{8'hFF}};
        end else begin
            if (swap) begin
                front_q <= back_q;
            end
            if (wr_acc) begin
                back_q[wr_digit_i] <= wr_seg_i;
            end
        end
    end

    assign wr_ready_o     = ~pending_q;
    assign commit_ready_o = ~pending_q;
    assign an_o           = an_q;
    assign seg_o          = seg_q;
    assign frame_done_o   = frame_done;
    assign step_tick_o    = step_tick;

endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Scoreboard bench for seg7_scan_scheduler: a time-based reference model pushes per-cycle
// expectations, and a negedge monitor pops and compares them against the DUT.
module tb_seg7_scan_scheduler;

    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int SF    = 3;
    localparam int SLOT  = BL + DW;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_digit;
    logic [7:0] wr_seg;
    logic       commit_valid;
    logic       commit_ready;
    logic [3:0] an;
    logic [7:0] seg;
    logic       frame_done;
    logic       step_tick;

    always #5 clk = ~clk;

    seg7_scan_scheduler #(
        .DWELL      (DW),
        .BLANK      (BL),
        .STEP_FRAMES(SF)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_valid_i    (wr_valid),
        .wr_ready_o    (wr_ready),
        .wr_digit_i    (wr_digit),
        .wr_seg_i      (wr_seg),
        .commit_valid_i(commit_valid),
        .commit_ready_o(commit_ready),
        .an_o          (an),
        .seg_o         (seg),
        .frame_done_o  (frame_done),
        .step_tick_o   (step_tick)
    );

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] seg;
        logic       fd;
        logic       st;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   mon_cyc = 0;

    // Reference model: cycle index since reset release plus the two banks and pending flag.
    int         t;
    logic [7:0] m_front[4];
    logic [7:0] m_back[4];
    logic       m_pend;

    function automatic exp_t model_out();
        exp_t e;
        int p, slot, off;
        p    = t % FRAME;
        slot = p / SLOT;
        off  = p % SLOT;
        e.an  = 4'b1111;
        e.seg = 8'hFF;
        if (off >= BL) begin
            e.an[slot] = 1'b0;
            e.seg      = m_front[slot];
        end
        e.fd  = (p == FRAME - 1);
        e.st  = e.fd && ((t / FRAME) % SF == SF - 1);
        e.rdy = !m_pend;
        return e;
    endfunction

    task automatic model_reset();
        t      = 0;
        m_pend = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m_front[i] = 8'hFF;
            m_back[i]  = 8'hFF;
        end
    endtask

    task automatic cyc(input logic r, input logic wv, input logic [1:0] wd,
                       input logic [7:0] ws, input logic cv);
        logic wacc, cacc, fd;
        reset        = r;
        wr_valid     = wv;
        wr_digit     = wd;
        wr_seg       = ws;
        commit_valid = cv;
        exp_q.push_back(model_out());
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            fd   = ((t % FRAME) == FRAME - 1);
            wacc = wv && !m_pend;
            cacc = cv && !m_pend;
            if (fd && (m_pend || cacc)) begin
                m_front = m_back;
                m_pend  = 1'b0;
            end else if (cacc) begin
                m_pend = 1'b1;
            end
            if (wacc) m_back[wd] = ws;
            t++;
        end
        #1;
    endtask

    task automatic check_now(input string tag);
        n_chk++;
        if (an === 4'b1111 && seg === 8'hFF && wr_ready === 1'b1 && commit_ready === 1'b1 &&
            frame_done === 1'b0 && step_tick === 1'b0) begin
            n_pass++;
        end else begin
            $display("FAIL %s an/seg/fd/step/wr_rdy/cm_rdy: actual %b/%h/%b/%b/%b/%b required 1111/ff/0/0/1/1",
                     tag, an, seg, frame_done, step_tick, wr_ready, commit_ready);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    endtask

    task automatic run_to(input int pos);
        for (int i = 0; i < FRAME && (t % FRAME) != pos; i++) cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b0);
    endtask

    always @(negedge clk) begin
        exp_t e, act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {an, seg, frame_done, step_tick, wr_ready};
            n_chk++;
            if (act == e && commit_ready == e.rdy) begin
                n_pass++;
            end else begin
                $display("FAIL cyc%0d an/seg/fd/step/wr_rdy/cm_rdy: actual %b/%h/%b/%b/%b/%b required %b/%h/%b/%b/%b/%b",
                         mon_cyc, an, seg, frame_done, step_tick, wr_ready, commit_ready,
                         e.an, e.seg, e.fd, e.st, e.rdy, e.rdy);
            end
            mon_cyc++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish within the wait limit");
        $finish;
    end

    initial begin
        reset        = 1'b1;
        wr_valid     = 1'b0;
        wr_digit     = 2'd0;
        wr_seg       = 8'h00;
        commit_valid = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        check_now("reset_state");

        // Load d0/d1, commit mid-frame, then hammer writes and commits while pending.
        cyc(1'b0, 1'b1, 2'd0, 8'h1F, 1'b0);
        cyc(1'b0, 1'b1, 2'd1, 8'h8F, 1'b0);
        idle(1);
        cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 2'd2, 8'h00, 1'b1);
        idle(2 * FRAME - 11);

        // Commit exactly on the frame boundary together with a write to a different byte.
        cyc(1'b0, 1'b1, 2'd0, 8'h55, 1'b0);
        run_to(FRAME - 1);
        cyc(1'b0, 1'b1, 2'd3, 8'hA5, 1'b1);
        idle(FRAME);
        run_to(FRAME - 1);
        cyc(1'b0, 1'b0, 2'd0, 8'h00, 1'b1);
        idle(4 * FRAME);

        // Reset during the idx-2 drive slot, then watch the step count restart.
        run_to(2 * SLOT + BL + 1);
        cyc(1'b1, 1'b0, 2'd0, 8'h00, 1'b0);
        check_now("mid_reset");
        idle(3 * FRAME + 8);

        for (int i = 0; i < 1500; i++) begin
            cyc($urandom_range(0, 499) == 0,
                $urandom_range(0, 1) == 1,
                2'($urandom_range(0, 3)),
                8'($urandom),
                $urandom_range(0, 15) == 0);
        end
        idle(2);

        @(negedge clk);
        #1;
        if (n_pass != n_chk) begin
            $display("FAIL summary: %0d of %0d checks failed", n_chk - n_pass, n_chk);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
